// File: rtl/ir_sequencer.sv
// Instruction sequencer for the IR/GPR datapath: fetches 32-bit instructions
// into IR, decodes the opcode in IR[31:27], strobes the datapath for
// arithmetic/logic/move ops and resolves jumps against latched datapath flags.
// Owns the program counter.
module ir_sequencer #(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     ir,
    output logic            exec_en,
    input  logic [3:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    // Bit positions inside the datapath flag vector {zero, sign, carry, overflow}.
    localparam int FL_Z = 3;
    localparam int FL_S = 2;
    localparam int FL_C = 1;
    localparam int FL_V = 0;

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      op;
    logic [3:0]      flag_q;
    logic            from_exec;
    logic            jump_taken;
    logic [PC_W-1:0] pc_nxt;

    assign op        = ir[31:27];
    assign imem_addr = pc;

    // Evaluate the jump condition for the opcode in IR against the flags
    // latched by the last datapath op (never the live flag inputs).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        jump_taken = 1'b0;
        case (op)
            5'd16:   jump_taken = 1'b1;
            5'd17:   jump_taken =  flag_q[FL_C];
            5'd18:   jump_taken = !flag_q[FL_C];
            5'd19:   jump_taken =  flag_q[FL_S];
            5'd20:   jump_taken = !flag_q[FL_S];
            5'd21:   jump_taken =  flag_q[FL_Z];
            5'd22:   jump_taken = !flag_q[FL_Z];
            5'd23:   jump_taken =  flag_q[FL_V];
            5'd24:   jump_taken = !flag_q[FL_V];
            default: jump_taken = 1'b0;
        endcase
    end

    // Next program counter: jump target from the low IR bits when taken,
    // otherwise sequential with silent wrap at the top of the program space.
    always_comb begin
        pc_nxt = pc + {{(PC_W-1){1'b0}}, 1'b1};
        if (jump_taken) begin
            pc_nxt = ir[PC_W-1:0];
        end
    end

    // Next-state and state-decoded outputs; outputs depend only on the
    // registered state so imem_valid/flags never reach an output combinationally.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        exec_en   = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                busy = 1'b1;
                if (op <= 5'd15)      state_nxt = S_EXEC;
                else if (op <= 5'd24) state_nxt = S_UPDATE;
                else                  state_nxt = S_HALT;
            end
            S_EXEC: begin
                exec_en   = 1'b1;
                busy      = 1'b1;
                state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                busy      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset wins over any pending fetch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer registers: IR load, sticky illegal, flag latch and PC update.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pc        <= '0;
            ir        <= '0;
            flag_q    <= '0;
            illegal   <= 1'b0;
            from_exec <= 1'b0;
        end else begin
            from_exec <= (state == S_EXEC);
            if (state == S_FETCH && imem_valid) begin
                ir <= imem_rdata;
            end
            if (state == S_DECODE && op >= 5'd26) begin
                illegal <= 1'b1;
            end
            if (state == S_UPDATE) begin
                // Flags are only meaningful the cycle after a datapath op.
                if (from_exec) begin
                    flag_q <= flags;
                end
                pc <= pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ir_sequencer.sv
// Scoreboard bench for ir_sequencer: tests push expected fetch/execute events
// (with cycle offsets from the start pulse) and a monitor pops and compares.
module tb_ir_sequencer;

    localparam int PC_W = 5;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            imem_valid = 1'b0;
    logic [31:0]     ir;
    logic            exec_en;
    logic [3:0]      flags = '0;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;
    logic            illegal;

    ir_sequencer #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ir         (ir),
        .exec_en    (exec_en),
        .flags      (flags),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_exec;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    logic [31:0] mem   [32];
    int          waits [32];
    logic [3:0]  test_flags = '0;
    logic        exec_last  = 1'b0;
    int          wait_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rdst,
                                       input logic [4:0] rsrc1, input logic imm,
                                       input logic [15:0] isrc);
        return {op, rdst, rsrc1, imm, isrc};
    endfunction

    task automatic expect_ev(input logic is_exec, input logic [31:0] data, input int rel);
        ev_t e;
        e.is_exec = is_exec;
        e.data    = data;
        e.cyc     = rel;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input logic is_exec, input logic [31:0] data, input int rel);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind=%0d data=0x%08h at cycle %0d, expected none",
                     is_exec, data, rel);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", {31'b0, is_exec}, {31'b0, e.is_exec});
            check(is_exec ? "exec_ir" : "fetch_addr", data, e.data);
            check("ev_cycle", rel, e.cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every fetch handshake and execute strobe.
    always @(negedge clk) begin
        if (imem_req && imem_valid) got_ev(1'b0, {27'b0, imem_addr}, cyc - t0);
        if (exec_en) got_ev(1'b1, ir, cyc - t0);
    end

    // Memory and datapath-flag responder, driven just after each edge.
    always @(posedge clk) begin
        #1;
        flags     = exec_last ? test_flags : ~test_flags;
        exec_last = exec_en;
        if (imem_req) begin
            if (wait_cnt >= waits[imem_addr]) begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            mem[i]   = mk(5'd25, 5'd0, 5'd0, 1'b0, 16'd0);
            waits[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        sys_rst = 1'b1;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic start_prog();
        @(posedge clk); #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc);
        int n = 0;
        while (!halted && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("halt_reached", {31'b0, halted}, 32'd1);
        @(negedge clk);
    endtask

    task automatic end_test(input string name);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    logic [31:0] add_w, mov_w, w;

    initial begin
        add_w = mk(5'd2, 5'd0, 5'd2, 1'b1, 16'd4);
        mov_w = mk(5'd0, 5'd1, 5'd0, 1'b1, 16'd7);

        // Reset state.
        clear_mem();
        do_reset();
        @(negedge clk);
        check("rst_pc", {27'b0, pc}, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_outs", {27'b0, imem_req, exec_en, busy, halted, illegal}, 32'd0);

        // Zero-wait ADD then HALT.
        clear_mem();
        mem[0] = add_w;
        start_prog();
        expect_ev(1'b0, 32'd0, 1);
        expect_ev(1'b1, add_w, 3);
        expect_ev(1'b0, 32'd1, 5);
        wait_halt(40);
        check("t1_pc", {27'b0, pc}, 32'd1);
        check("t1_status", {29'b0, busy, halted, illegal}, 32'b010);
        end_test("t1");

        // Three wait states on address 0.
        do_reset();
        clear_mem();
        mem[0]   = add_w;
        waits[0] = 3;
        expect_ev(1'b0, 32'd0, 4);
        expect_ev(1'b1, add_w, 6);
        expect_ev(1'b0, 32'd1, 8);
        start_prog();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_req_addr", {26'b0, imem_req, imem_addr}, 32'h20);
            check("t2_ir_held", ir, 32'd0);
        end
        wait_halt(40);
        check("t2_pc", {27'b0, pc}, 32'd1);
        end_test("t2");

        // MOV sets zero flag; jzero to 9 is taken.
        do_reset();
        clear_mem();
        test_flags = 4'b1000;
        mem[0] = mov_w;
        mem[1] = mk(5'd21, 5'd0, 5'd0, 1'b1, 16'd9);
        expect_ev(1'b0, 32'd0, 1);
        expect_ev(1'b1, mov_w, 3);
        expect_ev(1'b0, 32'd1, 5);
        expect_ev(1'b0, 32'd9, 8);
        start_prog();
        wait_halt(40);
        check("t3_pc", {27'b0, pc}, 32'd9);
        end_test("t3");

        // Same, jnozero falls through to 2.
        do_reset();
        clear_mem();
        mem[0] = mov_w;
        mem[1] = mk(5'd22, 5'd0, 5'd0, 1'b1, 16'd9);
        expect_ev(1'b0, 32'd0, 1);
        expect_ev(1'b1, mov_w, 3);
        expect_ev(1'b0, 32'd1, 5);
        expect_ev(1'b0, 32'd2, 8);
        start_prog();
        wait_halt(40);
        check("t4_pc", {27'b0, pc}, 32'd2);
        end_test("t4");
        test_flags = 4'b0000;

        // Unconditional jump to 31, MOV at 31, wrap to 0.
        do_reset();
        clear_mem();
        mem[0]  = mk(5'd16, 5'd0, 5'd0, 1'b1, 16'd31);
        mem[31] = mov_w;
        expect_ev(1'b0, 32'd0, 1);
        expect_ev(1'b0, 32'd31, 4);
        expect_ev(1'b1, mov_w, 6);
        expect_ev(1'b0, 32'd0, 8);
        start_prog();
        repeat (8) @(posedge clk);
        #1;
        end_test("t5");

        // Illegal opcode 28.
        do_reset();
        clear_mem();
        w      = mk(5'd28, 5'd0, 5'd0, 1'b0, 16'd3);
        mem[0] = w;
        expect_ev(1'b0, 32'd0, 1);
        start_prog();
        wait_halt(40);
        check("t6_status", {29'b0, busy, halted, illegal}, 32'b011);
        check("t6_pc", {27'b0, pc}, 32'd0);
        end_test("t6");
        start_prog();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_restart_ignored", {26'b0, imem_req, halted, pc}, 32'h20);
        check("t6_illegal_sticky", {31'b0, illegal}, 32'd1);
        end_test("t6b");

        // Reset during a long fetch wait at address 5.
        do_reset();
        clear_mem();
        mem[0]   = mk(5'd16, 5'd0, 5'd0, 1'b0, 16'd5);
        waits[5] = 20;
        expect_ev(1'b0, 32'd0, 1);
        start_prog();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t7_waiting", {26'b0, imem_req, imem_addr}, 32'h25);
        @(posedge clk); #1;
        sys_rst = 1'b1;
        @(posedge clk); #1;
        sys_rst = 1'b0;
        @(negedge clk);
        check("t7_rst_req", {31'b0, imem_req}, 32'd0);
        check("t7_rst_pc", {27'b0, pc}, 32'd0);
        check("t7_rst_ir", ir, 32'd0);
        check("t7_rst_idle", {30'b0, busy, halted}, 32'd0);
        end_test("t7");
        mem[0]   = mk(5'd25, 5'd0, 5'd0, 1'b0, 16'd0);
        waits[5] = 0;
        expect_ev(1'b0, 32'd0, 1);
        start_prog();
        wait_halt(40);
        check("t7_restart_pc", {27'b0, pc}, 32'd0);
        end_test("t7b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
